// File: rtl/riscv_multicycle_ctrl_if.sv
// Control bundle between the RV32I multi-cycle controller (master) and its datapath (slave).
interface riscv_multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_write;
  logic             adr_src;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_control;
  logic [1:0]       result_src;
  logic             instr_retired;
  logic [CNT_W-1:0] instret;
  logic             halted;

  modport master (
    input  opcode, funct3, funct7b5, zero, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_control, result_src,
           instr_retired, instret, halted
  );

  modport slave (
    output opcode, funct3, funct7b5, zero, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, alu_control, result_src,
           instr_retired, instret, halted
  );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Moore-style sequencer for the shared RV32I multi-cycle datapath with a
// retired-instruction counter and a sticky halt on unsupported encodings.
module riscv_multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_multicycle_ctrl_if.master bus
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_LUI, S_ILLEGAL
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] instret_q;
  logic [2:0]       alu_op;
  logic             funct3_alu_ok;

  // ALU operation for register/immediate arithmetic; sub only for R-type funct7b5
  always_comb begin
    alu_op        = ALU_ADD;
    funct3_alu_ok = 1'b1;
    case (bus.funct3)
      3'b000:  alu_op = (state == S_EXECR && bus.funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b100:  alu_op = ALU_XOR;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: funct3_alu_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_FETCH:    if (bus.mem_ready) state_n = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_n = S_MEMADR;
          OP_R:         state_n = funct3_alu_ok ? S_EXECR : S_ILLEGAL;
          OP_I:         state_n = funct3_alu_ok ? S_EXECI : S_ILLEGAL;
          OP_BR:        state_n = (bus.funct3[2:1] == 2'b00) ? S_BRANCH : S_ILLEGAL;
          OP_JAL:       state_n = S_JAL;
          OP_LUI:       state_n = S_LUI;
          default:      state_n = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_n = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_n = S_MEMWB;
      S_MEMWB:    state_n = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_n = S_FETCH;
      S_EXECR:    state_n = S_ALUWB;
      S_EXECI:    state_n = S_ALUWB;
      S_ALUWB:    state_n = S_FETCH;
      S_BRANCH:   state_n = S_FETCH;
      S_JAL:      state_n = S_ALUWB;
      S_LUI:      state_n = S_FETCH;
      S_ILLEGAL:  state_n = S_ILLEGAL;
      default:    state_n = S_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      instret_q <= '0;
    end else begin
      state <= state_n;
      if (bus.instr_retired) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Datapath controls follow the state register; everything is held low during reset
  always_comb begin
    bus.mem_req       = 1'b0;
    bus.mem_write     = 1'b0;
    bus.adr_src       = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 2'b00;
    bus.alu_src_b     = 2'b00;
    bus.alu_control   = ALU_ADD;
    bus.result_src    = 2'b00;
    bus.instr_retired = 1'b0;
    bus.halted        = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          bus.mem_req    = 1'b1;
          bus.alu_src_b  = 2'b10;
          bus.result_src = 2'b10;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
        end
        S_DECODE: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          bus.alu_src_a = 2'b10;
          bus.alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          bus.mem_req = 1'b1;
          bus.adr_src = 1'b1;
        end
        S_MEMWB: begin
          bus.result_src    = 2'b01;
          bus.reg_write     = 1'b1;
          bus.instr_retired = 1'b1;
        end
        S_MEMWRITE: begin
          bus.mem_req       = 1'b1;
          bus.mem_write     = 1'b1;
          bus.adr_src       = 1'b1;
          bus.instr_retired = bus.mem_ready;
        end
        S_EXECR: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_control = alu_op;
        end
        S_EXECI: begin
          bus.alu_src_a   = 2'b10;
          bus.alu_src_b   = 2'b01;
          bus.alu_control = alu_op;
        end
        S_ALUWB: begin
          bus.reg_write     = 1'b1;
          bus.instr_retired = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a     = 2'b10;
          bus.alu_control   = ALU_SUB;
          bus.pc_write      = bus.zero ^ bus.funct3[0];
          bus.instr_retired = 1'b1;
        end
        S_JAL: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          bus.pc_write  = 1'b1;
        end
        S_LUI: begin
          bus.alu_src_a     = 2'b11;
          bus.alu_src_b     = 2'b01;
          bus.result_src    = 2'b10;
          bus.reg_write     = 1'b1;
          bus.instr_retired = 1'b1;
        end
        S_ILLEGAL: bus.halted = 1'b1;
        default:   bus.halted = 1'b1;
      endcase
    end
  end

  assign bus.instret = instret_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Instruction-level scripted model of the controller; checks every cycle.
module tb_riscv_multicycle_ctrl;

  typedef logic [16:0] vec_t;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BR = 4, K_JAL = 5, K_LUI = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  riscv_multicycle_ctrl_if #(.CNT_W(32)) bus ();
  riscv_multicycle_ctrl_if #(.CNT_W(4))  bus4 ();

  riscv_multicycle_ctrl #(.CNT_W(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
  riscv_multicycle_ctrl #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

  assign bus4.opcode    = bus.opcode;
  assign bus4.funct3    = bus.funct3;
  assign bus4.funct7b5  = bus.funct7b5;
  assign bus4.zero      = bus.zero;
  assign bus4.mem_ready = bus.mem_ready;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc_in_instr;
  logic [31:0] model_cnt;

  // {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, srcA, srcB, alu, result_src, retired, halted}
  function automatic vec_t mk(input logic mr, input logic mw, input logic as, input logic irw,
                              input logic pcw, input logic rw, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [2:0] ac, input logic [1:0] rs,
                              input logic ret, input logic h);
    return {mr, mw, as, irw, pcw, rw, sa, sb, ac, rs, ret, h};
  endfunction

  function automatic vec_t dut_vec();
    return {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_write,
            bus.alu_src_a, bus.alu_src_b, bus.alu_control, bus.result_src,
            bus.instr_retired, bus.halted};
  endfunction

  function automatic logic [2:0] alu_exp(input logic [2:0] f3, input logic is_r, input logic f7);
    case (f3)
      3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [6:0] op_of(input int k);
    case (k)
      K_LW:    return 7'b0000011;
      K_SW:    return 7'b0100011;
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      default: return 7'b0110111;
    endcase
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare at the falling edge, advance the model counter
  task automatic cyc(input logic mr, input logic z, input vec_t e, input string tag);
    bus.mem_ready = mr;
    bus.zero      = z;
    @(negedge clk);
    chk({tag, " outputs"}, 64'(dut_vec()), 64'(e));
    chk({tag, " instret"}, 64'(bus.instret), 64'(model_cnt));
    chk({tag, " instret4"}, 64'(bus4.instret), 64'(model_cnt[3:0]));
    @(posedge clk);
    if (e[1]) model_cnt = model_cnt + 32'd1;
    #1;
    cyc_in_instr++;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    model_cnt = '0;
    #1;
    chk("reset outputs", 64'(dut_vec()), 64'd0);
    chk("reset instret", 64'(bus.instret), 64'd0);
    chk("reset instret4", 64'(bus4.instret), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset hold outputs", 64'(dut_vec()), 64'd0);
    reset = 1'b0;
  endtask

  task automatic fetch_decode(input int fs);
    repeat (fs) cyc(1'b0, rnd(), mk(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b10,0,0), "fetch");
    cyc(1'b1, rnd(), mk(1,0,0,1,1,0,2'b00,2'b10,3'b000,2'b10,0,0), "fetch");
    cyc(rnd(), rnd(), mk(0,0,0,0,0,0,2'b01,2'b01,3'b000,2'b00,0,0), "decode");
  endtask

  // zsel: 0/1 forces the zero flag in BRANCH, 2 randomizes it
  task automatic run(input int kind, input logic [2:0] f3, input logic f7, input int fs,
                     input int ms, input int zsel, output int ncyc);
    logic z;
    bus.opcode   = op_of(kind);
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    cyc_in_instr = 0;
    fetch_decode(fs);
    case (kind)
      K_LW: begin
        cyc(rnd(), rnd(), mk(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,0,0), "memadr");
        repeat (ms) cyc(1'b0, rnd(), mk(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0), "memread");
        cyc(1'b1, rnd(), mk(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0), "memread");
        cyc(rnd(), rnd(), mk(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b01,1,0), "memwb");
      end
      K_SW: begin
        cyc(rnd(), rnd(), mk(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,0,0), "memadr");
        repeat (ms) cyc(1'b0, rnd(), mk(1,1,1,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0), "memwrite");
        cyc(1'b1, rnd(), mk(1,1,1,0,0,0,2'b00,2'b00,3'b000,2'b00,1,0), "memwrite");
      end
      K_R, K_I: begin
        cyc(rnd(), rnd(), mk(0,0,0,0,0,0,2'b10, (kind == K_R) ? 2'b00 : 2'b01,
                             alu_exp(f3, kind == K_R, f7), 2'b00, 0, 0), "exec");
        cyc(rnd(), rnd(), mk(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,1,0), "aluwb");
      end
      K_BR: begin
        z = (zsel == 2) ? rnd() : 1'(zsel);
        cyc(rnd(), z, mk(0,0,0,0,z ^ f3[0],0,2'b10,2'b00,3'b001,2'b00,1,0), "branch");
      end
      K_JAL: begin
        cyc(rnd(), rnd(), mk(0,0,0,0,1,0,2'b01,2'b10,3'b000,2'b00,0,0), "jal");
        cyc(rnd(), rnd(), mk(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,1,0), "aluwb");
      end
      default: begin
        cyc(rnd(), rnd(), mk(0,0,0,0,0,1,2'b11,2'b01,3'b000,2'b10,1,0), "lui");
      end
    endcase
    ncyc = cyc_in_instr;
  endtask

  task automatic run_illegal(input logic [6:0] op, input logic [2:0] f3);
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7b5 = rnd();
    fetch_decode(0);
    repeat (20) cyc(rnd(), rnd(), mk(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,0,1), "illegal");
    do_reset();
  endtask

  logic [2:0] alu_f3s [5] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111};

  initial begin
    int nc;
    int k;
    logic [2:0] f3;
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.funct3    = '0;
    bus.funct7b5  = 1'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    model_cnt     = '0;
    @(posedge clk);
    #1;
    do_reset();

    run(K_R, 3'b000, 1'b0, 0, 0, 2, nc);
    chk("add cycles", 64'(nc), 64'd4);
    chk("add instret", 64'(bus.instret), 64'd1);
    run(K_R, 3'b000, 1'b1, 0, 0, 2, nc);
    run(K_I, 3'b000, 1'b1, 0, 0, 2, nc);
    run(K_LW, 3'b010, 1'b0, 3, 2, 2, nc);
    chk("lw stalled cycles", 64'(nc), 64'd10);
    run(K_LW, 3'b010, 1'b0, 0, 0, 2, nc);
    chk("lw cycles", 64'(nc), 64'd5);
    run(K_SW, 3'b010, 1'b0, 0, 0, 2, nc);
    chk("sw cycles", 64'(nc), 64'd4);
    run(K_BR, 3'b000, 1'b0, 0, 0, 1, nc);
    chk("beq cycles", 64'(nc), 64'd3);
    run(K_BR, 3'b001, 1'b0, 0, 0, 1, nc);
    chk("bne cycles", 64'(nc), 64'd3);
    run(K_JAL, 3'b000, 1'b0, 0, 0, 2, nc);
    chk("jal cycles", 64'(nc), 64'd4);
    run(K_LUI, 3'b101, 1'b0, 0, 0, 2, nc);
    chk("lui cycles", 64'(nc), 64'd3);
    chk("directed instret", 64'(bus.instret), 64'd10);

    for (int i = 0; i < 300; i++) begin
      k = int'($urandom_range(0, 6));
      if (k == K_R || k == K_I) f3 = alu_f3s[$urandom_range(0, 4)];
      else if (k == K_BR)       f3 = {2'b00, rnd()};
      else                      f3 = 3'($urandom);
      run(k, f3, rnd(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 2, nc);
    end

    run_illegal(7'b1111111, 3'b000);
    run_illegal(7'b0110011, 3'b001);
    run_illegal(7'b1100011, 3'b010);

    for (int i = 0; i < 17; i++) run(K_LUI, 3'($urandom), rnd(), 0, 0, 2, nc);
    chk("lui17 instret4", 64'(bus4.instret), 64'd1);
    chk("lui17 instret", 64'(bus.instret), 64'd17);

    // Abort a load while it waits in MEMREAD
    bus.opcode = op_of(K_LW);
    bus.funct3 = 3'b010;
    fetch_decode(0);
    cyc(rnd(), rnd(), mk(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,0,0), "memadr");
    cyc(1'b0, rnd(), mk(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,0,0), "memread");
    bus.mem_ready = 1'b1;
    do_reset();
    chk("abort instret", 64'(bus.instret), 64'd0);
    run(K_LW, 3'b010, 1'b0, 1, 1, 2, nc);
    chk("post-abort lw cycles", 64'(nc), 64'd7);
    chk("post-abort instret", 64'(bus.instret), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
